// File: rtl/fetch_sequencer.sv
// Program-counter sequencer between the instruction ROM and the decode stage.
// Define FETCH_SEQ_PERF_CNT_EN to add the fetch/stall performance counters.
module fetch_sequencer #(
   parameter int unsigned         INST_WIDTH   = 32,
   parameter int unsigned         MAX_NUM_INST = 128,
   parameter int unsigned         PC_WIDTH     = 32,
   parameter logic [PC_WIDTH-1:0] RESET_PC     = '0,
   localparam int unsigned        ADDR_W       = $clog2(MAX_NUM_INST)
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  start_i,
   input  logic                  halt_i,
   output logic [ADDR_W-1:0]     rom_addr_o,
   input  logic [INST_WIDTH-1:0] rom_inst_i,
   output logic                  inst_valid_o,
   input  logic                  inst_ready_i,
   output logic [INST_WIDTH-1:0] inst_o,
   output logic [PC_WIDTH-1:0]   inst_pc_o,
   input  logic                  redirect_i,
   input  logic [PC_WIDTH-1:0]   redirect_pc_i,
   output logic                  busy_o,
`ifdef FETCH_SEQ_PERF_CNT_EN
   output logic [31:0]           fetch_cnt_o,
   output logic [31:0]           stall_cnt_o,
`endif
   output logic                  err_o
);

   typedef enum logic [1:0] {IDLE, RUN, DONE, ERR} state_t;

   localparam logic [PC_WIDTH-3:0] LAST_WORD = (PC_WIDTH-2)'(MAX_NUM_INST - 1);
   localparam logic [PC_WIDTH-3:0] NUM_WORDS = (PC_WIDTH-2)'(MAX_NUM_INST);

   state_t                  state_q, state_d;
   logic [PC_WIDTH-1:0]     pc_q, pc_d;
   logic                    valid_d, err_d, fire;
   logic [INST_WIDTH-1:0]   inst_d;
   logic [PC_WIDTH-1:0]     inst_pc_d;
   logic                    redirect_ok;

   assign rom_addr_o  = pc_q[ADDR_W+1:2];
   assign redirect_ok = (redirect_pc_i[1:0] == 2'b00) &&
                        (redirect_pc_i[PC_WIDTH-1:2] < NUM_WORDS);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= IDLE;
         pc_q         <= RESET_PC;
         inst_valid_o <= 1'b0;
         inst_o       <= '0;
         inst_pc_o    <= '0;
         err_o        <= 1'b0;
         busy_o       <= 1'b0;
      end else begin
         state_q      <= state_d;
         pc_q         <= pc_d;
         inst_valid_o <= valid_d;
         inst_o       <= inst_d;
         inst_pc_o    <= inst_pc_d;
         err_o        <= err_d;
         busy_o       <= (state_d == RUN);
      end
   end

   // Redirect outranks halt, which outranks a fetch; a handshake always retires the output.
   always_comb begin
      state_d   = state_q;
      pc_d      = pc_q;
      valid_d   = inst_valid_o;
      inst_d    = inst_o;
      inst_pc_d = inst_pc_o;
      err_d     = err_o;
      fire      = 1'b0;

      if (inst_valid_o && inst_ready_i) valid_d = 1'b0;

      case (state_q)
         IDLE: begin
            if (start_i) begin
               state_d = RUN;
               pc_d    = RESET_PC;
            end
         end
         RUN, DONE: begin
            if (redirect_i) begin
               valid_d = 1'b0;
               if (redirect_ok) begin
                  pc_d    = redirect_pc_i;
                  state_d = RUN;
               end else begin
                  err_d   = 1'b1;
                  state_d = ERR;
               end
            end else if (state_q == RUN) begin
               if (halt_i) begin
                  state_d = DONE;
               end else if (!inst_valid_o || inst_ready_i) begin
                  fire      = 1'b1;
                  inst_d    = rom_inst_i;
                  inst_pc_d = pc_q;
                  valid_d   = 1'b1;
                  pc_d      = pc_q + PC_WIDTH'(4);
                  if (pc_q[PC_WIDTH-1:2] == LAST_WORD) state_d = DONE;
               end
            end
         end
         default: begin
            state_d = state_q;
         end
      endcase
   end

`ifdef FETCH_SEQ_PERF_CNT_EN
   // Saturating counters so long runs never wrap back to small values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         fetch_cnt_o <= '0;
         stall_cnt_o <= '0;
      end else begin
         if (fire && (fetch_cnt_o != 32'hFFFF_FFFF))
            fetch_cnt_o <= fetch_cnt_o + 32'd1;
         if (inst_valid_o && !inst_ready_i && (stall_cnt_o != 32'hFFFF_FFFF))
            stall_cnt_o <= stall_cnt_o + 32'd1;
      end
   end
`endif

endmodule
